// File: rtl/ram_readback_checker_if.sv
// RAM controller command/readback bus used by ram_readback_checker.
interface ram_readback_checker_if;
  logic        ram_instruction;
  logic        ram_latch;
  logic [23:1] ram_addr;
  logic [15:0] ram_data;
  logic        ram_ready;

  modport master (
    output ram_instruction,
    output ram_latch,
    output ram_addr,
    input  ram_data,
    input  ram_ready
  );

  modport slave (
    input  ram_instruction,
    input  ram_latch,
    input  ram_addr,
    output ram_data,
    output ram_ready
  );
endinterface

// File: rtl/ram_readback_checker.sv
// Reads a block of RAM words and compares each against seed + index.
// Optional watchdog on the wait states is enabled by defining RAMCHK_TIMEOUT_EN.
module ram_readback_checker #(
  parameter logic        READ           = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [23:1]                   base_addr,
  input  logic [15:0]                   word_count,
  input  logic [15:0]                   seed,
  ram_readback_checker_if.master        ram,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [15:0]                   error_count,
  output logic [23:1]                   first_err_addr,
  output logic [15:0]                   first_err_data
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitAck  = 3'd2;
  localparam logic [2:0] StWaitData = 3'd3;
  localparam logic [2:0] StCheck    = 3'd4;
  localparam logic [2:0] StFinish   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [23:1] addr_q;
  logic [15:0] count_q, seed_q, index_q, data_q, err_q;
  logic [23:1] ferr_addr_q;
  logic [15:0] ferr_data_q;
  logic        busy_q, done_q, pass_q;
  logic        accept, mismatch, last_word, wd_expired, timeout_hit;

  assign accept    = (state_q == StIdle) && start;
  assign mismatch  = (data_q != 16'(seed_q + index_q));
  assign last_word = (16'(index_q + 16'd1) == count_q);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle:     if (start) state_d = (word_count == 16'd0) ? StFinish : StIssue;
      StIssue:    if (ram.ram_ready) state_d = StWaitAck;
      StWaitAck: begin
        if (!ram.ram_ready) begin
          state_d = StWaitData;
        end else if (wd_expired) begin
          state_d     = StFinish;
          timeout_hit = 1'b1;
        end
      end
      StWaitData: begin
        if (ram.ram_ready) begin
          state_d = StCheck;
        end else if (wd_expired) begin
          state_d     = StFinish;
          timeout_hit = 1'b1;
        end
      end
      StCheck:    state_d = last_word ? StFinish : StIssue;
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      seed_q      <= '0;
      index_q     <= '0;
      data_q      <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFinish);
      case (state_q)
        StIdle: begin
          if (start) begin
            addr_q      <= base_addr;
            count_q     <= word_count;
            seed_q      <= seed;
            index_q     <= '0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StWaitData: if (ram.ram_ready) data_q <= ram.ram_data;
        StCheck: begin
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            // err_q is cleared on start, so zero means no earlier mismatch this run
            if (err_q == 16'd0) begin
              ferr_addr_q <= addr_q;
              ferr_data_q <= data_q;
            end
          end
          index_q <= index_q + 16'd1;
          addr_q  <= addr_q + 23'd1;
        end
        StFinish: begin
          busy_q <= 1'b0;
          pass_q <= (err_q == 16'd0) && !timeout;
        end
        default: ;
      endcase
    end
  end

`ifdef RAMCHK_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        timeout_q;
  logic        waiting;

  assign waiting    = (state_q == StWaitAck) || (state_q == StWaitData);
  assign wd_expired = waiting && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change so each wait state gets its own budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) wd_q <= '0;
      else if (waiting)       wd_q <= wd_q + 32'd1;
      if (accept)           timeout_q <= 1'b0;
      else if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES ^ accept;
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign ram.ram_instruction = READ;
  assign ram.ram_latch       = (state_q == StIssue) && ram.ram_ready;
  assign ram.ram_addr        = addr_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench for ram_readback_checker with a one-cycle-latency RAM model.
module tb_ram_readback_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:1] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [15:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] error_count, first_err_data;
  logic [23:1] first_err_addr;

  ram_readback_checker_if ram_bus ();

  ram_readback_checker #(
    .READ           (1'b0),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .ram            (ram_bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          latch_cnt = 0;
  int          done_cnt = 0;
  logic [23:1] addr_log [64];
  logic [23:1] lat_addr;
  bit          corrupt = 1'b0;
  bit          hang = 1'b0;

  // RAM model: drop ready after a latch, return data one edge later unless hung
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_bus.ram_ready <= 1'b1;
      ram_bus.ram_data  <= '0;
      lat_addr          <= '0;
    end else if (ram_bus.ram_latch) begin
      lat_addr                 <= ram_bus.ram_addr;
      ram_bus.ram_ready        <= 1'b0;
      addr_log[latch_cnt % 64] <= ram_bus.ram_addr;
      latch_cnt                <= latch_cnt + 1;
    end else if (!ram_bus.ram_ready && !hang) begin
      ram_bus.ram_ready <= 1'b1;
      ram_bus.ram_data  <= (corrupt && lat_addr == 23'h4) ? 16'hDEAD : lat_addr[16:1];
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [23:1] b, input logic [15:0] c, input logic [15:0] s);
    base_addr  = b;
    word_count = c;
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_latches(input string tag, input int base, input int want);
    int n = 0;
    while (latch_cnt - base < want && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(latch_cnt - base), 32'(want));
  endtask

  initial begin
    int snap, dsnap, cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_latch", 32'(ram_bus.ram_latch), 32'd0);
    check("rst_addr", 32'(ram_bus.ram_addr), 32'd0);
    check("rst_instr", 32'(ram_bus.ram_instruction), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run: data = addr[16:1] matches seed + index when seed = base
    snap  = latch_cnt;
    dsnap = done_cnt;
    pulse_start(23'h1, 16'd8, 16'd1);
    check("run_busy", 32'(busy), 32'd1);
    wait_done("run_done", 200);
    check("run_pass", 32'(pass), 32'd1);
    check("run_err", 32'(error_count), 32'd0);
    check("run_busy_end", 32'(busy), 32'd0);
    check("run_latches", 32'(latch_cnt - snap), 32'd8);
    @(negedge clk);
    check("run_done_pulse", 32'(done), 32'd0);
    check("run_done_cnt", 32'(done_cnt - dsnap), 32'd1);

    // Same run with the word at address 4 corrupted
    corrupt = 1'b1;
    pulse_start(23'h1, 16'd8, 16'd1);
    wait_done("bad_done", 200);
    check("bad_err", 32'(error_count), 32'd1);
    check("bad_faddr", 32'(first_err_addr), 32'h4);
    check("bad_fdata", 32'(first_err_data), 32'hDEAD);
    check("bad_pass", 32'(pass), 32'd0);
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_hold_err", 32'(error_count), 32'd1);

    // Address wrap at top of space
    snap = latch_cnt;
    pulse_start(23'h7FFFFE, 16'd4, 16'hFFFE);
    wait_done("wrap_done", 200);
    check("wrap_a0", 32'(addr_log[(snap + 0) % 64]), 32'h7FFFFE);
    check("wrap_a1", 32'(addr_log[(snap + 1) % 64]), 32'h7FFFFF);
    check("wrap_a2", 32'(addr_log[(snap + 2) % 64]), 32'h000000);
    check("wrap_a3", 32'(addr_log[(snap + 3) % 64]), 32'h000001);
    check("wrap_pass", 32'(pass), 32'd1);
    @(negedge clk);

    // Zero-length run: done exactly two cycles after start
    snap = latch_cnt;
    pulse_start(23'h10, 16'd0, 16'd0);
    check("zero_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(done), 32'd1);
    check("zero_pass", 32'(pass), 32'd1);
    check("zero_latches", 32'(latch_cnt - snap), 32'd0);
    @(negedge clk);

    // Reset in WAIT_DATA of word 3; a second start while busy must be ignored
    snap  = latch_cnt;
    pulse_start(23'h1, 16'd8, 16'd1);
    wait_latches("mid_lat2", snap, 2);
    pulse_start(23'h100, 16'd2, 16'h55);
    wait_latches("mid_lat4", snap, 4);
    @(negedge clk);
    check("mid_addr", 32'(ram_bus.ram_addr), 32'h4);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_err", 32'(error_count), 32'd0);
    check("mid_a1", 32'(addr_log[(snap + 1) % 64]), 32'h2);
    dsnap = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(ram_bus.ram_addr), 32'd0);
    check("mrst_latch", 32'(ram_bus.ram_latch), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - dsnap), 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);
    check("mrst_no_lat", 32'(latch_cnt - snap), 32'd4);

    // Controller never reasserts ready
    hang = 1'b1;
    snap  = latch_cnt;
    dsnap = done_cnt;
    pulse_start(23'h10, 16'd2, 16'd0);
    wait_latches("hang_lat", snap, 1);
`ifdef RAMCHK_TIMEOUT_EN
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_window", 32'(cyc >= 15 && cyc <= 19), 32'd1);
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_pass", 32'(pass), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
`else
    cyc = 0;
    repeat (100) @(negedge clk);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_no_done", 32'(done_cnt - dsnap), 32'd0);
    check("hang_tmo", 32'(timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_readback_checker.md
RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

Interface
REQ-001 SHALL have parameter READ, default 0: instruction code driven on ram_instruction for a read.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: watchdog limit per read, in clk cycles.
REQ-003 SHALL have the following ports, clock and reset first:
- clk  input  1: single clock; all logic on posedge.
- rst_n  input  1: asynchronous, active-low reset.
- start  input  1: one-cycle pulse that begins a readback run.
- base_addr  input  23 [23:1]: first word address.
- word_count  input  16: number of words to check.
- seed  input  16: expected data at base_addr.
- ram_instruction  output  1: command to the RAM controller; always READ.
- ram_latch  output  1: one-cycle command strobe.
- ram_addr  output  23 [23:1]: read address.
- ram_data  input  16: read data from the controller.
- ram_ready  input  1: controller idle / read data valid.
- busy  output  1: run in progress.
- done  output  1: one-cycle pulse at end of run.
- pass  output  1: last run had zero mismatches and no timeout.
- timeout  output  1: last run aborted by watchdog.
- error_count  output  16: mismatches in the current or last run.
- first_err_addr  output  23: address of the first mismatch.
- first_err_data  output  16: data read at the first mismatch.

Function
REQ-004 SHALL implement the states IDLE, ISSUE, WAIT_ACK, WAIT_DATA, CHECK and FINISH.
REQ-005 IDLE: start=1 SHALL latch base_addr, word_count and seed, clear error_count, pass, timeout and first_err_*, and set busy; next state SHALL be FINISH if word_count=0, else ISSUE.
REQ-006 ISSUE: ram_latch SHALL be driven 1 for exactly one cycle, and only while ram_ready=1; if ram_ready=0 the state SHALL hold with ram_latch=0. Next state SHALL be WAIT_ACK.
REQ-007 WAIT_ACK SHALL wait for ram_ready=0, then go to WAIT_DATA.
REQ-008 WAIT_DATA SHALL wait for ram_ready=1, register ram_data, then go to CHECK.
REQ-009 CHECK SHALL compare the registered data with expected = seed + index (mod 2^16), where index counts from 0.
- On mismatch, error_count SHALL increment, saturating at 16'hFFFF.
- On the first mismatch only, first_err_addr and first_err_data SHALL be captured.
REQ-010 After CHECK, index and ram_addr SHALL increment; ram_addr SHALL wrap from 23'h7FFFFF to 0. Next state SHALL be FINISH when index+1 = word_count, else ISSUE.
REQ-011 FINISH SHALL pulse done for one cycle, set pass = (error_count=0 && !timeout), clear busy and return to IDLE.
REQ-012 ram_addr SHALL be stable from ISSUE through CHECK of the same word.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 Minimum time per word SHALL be 4 cycles (ISSUE, WAIT_ACK, WAIT_DATA, CHECK) when the controller responds immediately.
REQ-015 pass, timeout, error_count and first_err_* SHALL hold their values until the next accepted start.

Reset
REQ-016 rst_n=0 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- ram_latch=0, ram_addr=0, ram_instruction=READ;
- busy=0, done=0, pass=0, timeout=0;
- error_count=0, first_err_addr=0, first_err_data=0.
REQ-017 Reset asserted mid-run SHALL abandon the run with no done pulse; after rst_n rises, a new start SHALL be required.

Configuration
REQ-018 Macro RAMCHK_TIMEOUT_EN SHALL control the watchdog.
- Defined: a counter SHALL run in WAIT_ACK and WAIT_DATA and clear on each state change. On reaching TIMEOUT_CYCLES it SHALL set timeout=1 and go to FINISH, so pass=0.
- Undefined: no counter SHALL be built, the wait states SHALL wait indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-019 base=0x000001, count=8, seed=1, model returns data=addr[16:1] -> 8 latch pulses, done, pass=1, error_count=0.
REQ-020 Same run with word at addr 0x000004 corrupted to 16'hDEAD -> error_count=1, first_err_addr=0x000004, first_err_data=16'hDEAD, pass=0.
REQ-021 base=0x7FFFFE, count=4 -> ram_addr sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
REQ-022 count=0 -> done exactly 2 cycles after start, with no ram_latch pulse and pass=1.
REQ-023 RAMCHK_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, model never reasserts ram_ready -> timeout=1 and done about 15 cycles after WAIT_DATA entry; undefined -> busy stays 1.
REQ-024 rst_n pulled low during WAIT_DATA of word 3 -> all outputs at reset values immediately with no done; a second start pulse during busy is ignored.
